// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline constants for the IF/ID boundary: reset vector, bundle width,
// {pc, inst} field layout and the canonical NOP encoding.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h1c00_0000;
    localparam int          ID_DATA_W_DEF = 64;

    localparam int          ID_INST_LSB   = 0;
    localparam int          ID_PC_LSB     = 32;
    localparam int          FIELD_W       = 32;

    localparam logic [31:0] NOP_INST      = 32'h0340_0000;

    // Packs pc and instruction into the bundle decode unpacks with the same offsets.
    function automatic logic [ID_DATA_W_DEF-1:0] pack_id(input logic [31:0] pc,
                                                         input logic [31:0] inst);
        logic [ID_DATA_W_DEF-1:0] data;
        data = {ID_DATA_W_DEF{1'b0}};
        data[ID_PC_LSB   +: FIELD_W] = pc;
        data[ID_INST_LSB +: FIELD_W] = inst;
        return data;
    endfunction

endpackage

// File: rtl/if_fetch_unit_inst_skid_buf.sv
// One-entry instruction buffer: catches SRAM read data on the first decode stall
// cycle and serves it until the next fetch edge.
module inst_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_i,
    input  logic        if_allow_in_i,
    input  logic        if_valid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] inst_o
);

    logic        buf_valid_q;
    logic        buf_valid_d;
    logic [31:0] inst_buf_q;
    logic [31:0] inst_buf_d;

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0000_0000;
        end else begin
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    // A fetch edge retires the buffer; the first stall cycle captures the SRAM output.
    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (fetch_i) begin
            buf_valid_d = 1'b0;
        end else if (if_valid_i && !buf_valid_q && !if_allow_in_i) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = rdata_i;
        end else begin
            buf_valid_d = buf_valid_q;
            inst_buf_d  = inst_buf_q;
        end
    end

    // Instruction select; an empty IF presents zero so the bundle never carries SRAM garbage.
    always_comb begin
        inst_o = 32'h0000_0000;
        if (!if_valid_i) begin
            inst_o = 32'h0000_0000;
        end else if (buf_valid_q) begin
            inst_o = inst_buf_q;
        end else begin
            inst_o = rdata_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: next-PC generation, synchronous-read SRAM request, and the
// valid/allow_in handshake towards decode with taken-branch redirects.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          ID_DATA_W = ID_DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 inst_sram_en,
    output logic [3:0]           inst_sram_we,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic [31:0]          inst_sram_rdata,
    input  logic                 id_allow_in,
    input  logic                 br_taken,
    input  logic [31:0]          br_target,
    output logic                 if_to_id_valid,
    output logic [ID_DATA_W-1:0] if_to_id_data
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        if_valid_q;
    logic        if_valid_d;

    logic        redirect_s;
    logic [31:0] nextpc_s;
    logic        if_allow_in_s;
    logic        fetch_s;
    logic [31:0] inst_s;

    // A branch redirects only when it actually leaves decode this cycle.
    assign redirect_s    = br_taken & id_allow_in;
    assign nextpc_s      = redirect_s ? br_target : (pc_q + 32'd4);
    assign if_allow_in_s = ~if_valid_q | id_allow_in | redirect_s;
    assign fetch_s       = ~reset & if_allow_in_s;

    assign inst_sram_en    = fetch_s;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc_s;
    assign inst_sram_wdata = 32'h0000_0000;

    // PC / valid register; reset parks pc one word early so nextpc lands on the vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC - 32'd4;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Advance on every fetch edge, otherwise hold.
    always_comb begin
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if (fetch_s) begin
            pc_d       = nextpc_s;
            if_valid_d = 1'b1;
        end else begin
            pc_d       = pc_q;
            if_valid_d = if_valid_q;
        end
    end

    inst_skid_buf u_skid (
        .clk           (clk),
        .reset         (reset),
        .fetch_i       (fetch_s),
        .if_allow_in_i (if_allow_in_s),
        .if_valid_i    (if_valid_q),
        .rdata_i       (inst_sram_rdata),
        .inst_o        (inst_s)
    );

    // The wrong-path instruction behind a leaving branch is squashed here.
    assign if_to_id_valid = if_valid_q & ~redirect_s;
    assign if_to_id_data  = ID_DATA_W'(pack_id(pc_q, inst_s));

endmodule
